// File: rtl/alu_slice_responder.sv
// Purpose: responder-side ALU that evaluates ADD/SUB/XOR/SLT/AND/NAND/NOR/OR in SLICE_W-bit slices.
// Latency: accept at edge k, resp_valid rises after edge k+N (N = 32/SLICE_W); N+2 cycles per op minimum.
// Backpressure: req_ready only in IDLE; response held stable in DONE until resp_ready.
module alu_slice_responder #(
  parameter int SLICE_W = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_command,
  input  logic [31:0]        req_operand_a,
  input  logic [31:0]        req_operand_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_result,
  output logic               resp_carryout,
  output logic               resp_zero,
  output logic               resp_overflow,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam int N     = 32 / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state;
  logic [2:0]         cmd_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;

  logic [31:0]        base;
  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W-1:0] slice_res;
  logic [SLICE_W:0]   sum_w;
  logic               is_sub;
  logic               is_addsub;
  logic               c_top_in;
  logic               ovf;
  logic               lt;
  logic               last;
  logic [31:0]        res_next;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // Slice datapath: one narrow adder plus bitwise ops on the current slice.
  always_comb begin
    base      = 32'(idx) * 32'(SLICE_W);
    a_s       = a_q[base +: SLICE_W];
    b_s       = b_q[base +: SLICE_W];
    is_sub    = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    is_addsub = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
    b_eff     = is_sub ? ~b_s : b_s;
    sum_w     = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_q};
    // Carry into the slice's top bit recovered from the sum bit itself.
    c_top_in  = a_s[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum_w[SLICE_W-1];
    ovf       = c_top_in ^ sum_w[SLICE_W];
    lt        = sum_w[SLICE_W-1] ^ ovf;
    case (cmd_q)
      CMD_XOR:  slice_res = a_s ^ b_s;
      CMD_AND:  slice_res = a_s & b_s;
      CMD_NAND: slice_res = ~(a_s & b_s);
      CMD_NOR:  slice_res = ~(a_s | b_s);
      CMD_OR:   slice_res = a_s | b_s;
      default:  slice_res = sum_w[SLICE_W-1:0];
    endcase
    res_next = resp_result;
    res_next[base +: SLICE_W] = slice_res;
    last = (idx == IDX_W'(N - 1));
  end

  // Control FSM with registered result, flags and completed-op counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      idx           <= '0;
      carry_q       <= 1'b0;
      resp_result   <= '0;
      resp_carryout <= 1'b0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q   <= req_command;
            a_q     <= req_operand_a;
            b_q     <= req_operand_b;
            idx     <= '0;
            carry_q <= (req_command == CMD_SUB) || (req_command == CMD_SLT);
            state   <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= res_next;
          carry_q     <= sum_w[SLICE_W];
          idx         <= idx + 1'b1;
          if (last) begin
            if (cmd_q == CMD_SLT) begin
              resp_result <= {31'b0, lt};
              resp_zero   <= ~lt;
            end else begin
              resp_zero   <= (res_next == 32'd0);
            end
            resp_carryout <= is_addsub & sum_w[SLICE_W];
            resp_overflow <= is_addsub & ovf;
            state         <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            op_count <= op_count + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_responder.sv
// Bench for alu_slice_responder at SLICE_W = 8, 1 and 32 sharing one clock and reset.
// Expected results come from a 33-bit reference model pushed to a scoreboard at issue.
// One instance is active at a time; the others idle with valid/ready gated off.
module tb_alu_slice_responder;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [2:0]  req_command = 3'd0;
  logic [31:0] req_operand_a = '0;
  logic [31:0] req_operand_b = '0;
  int          sel = 0;

  logic        req_ready_w [3];
  logic        resp_valid_w [3];
  logic [31:0] resp_result_w [3];
  logic        resp_carryout_w [3];
  logic        resp_zero_w [3];
  logic        resp_overflow_w [3];
  logic        busy_w [3];
  logic [15:0] op_count_w [3];

  exp_t sb[$];
  int   exp_cnt [3];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_slice_responder #(.SLICE_W(g == 0 ? 8 : (g == 1 ? 1 : 32)), .COUNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid && (sel == g)),
      .req_ready    (req_ready_w[g]),
      .req_command  (req_command),
      .req_operand_a(req_operand_a),
      .req_operand_b(req_operand_b),
      .resp_valid   (resp_valid_w[g]),
      .resp_ready   (resp_ready && (sel == g)),
      .resp_result  (resp_result_w[g]),
      .resp_carryout(resp_carryout_w[g]),
      .resp_zero    (resp_zero_w[g]),
      .resp_overflow(resp_overflow_w[g]),
      .busy         (busy_w[g]),
      .op_count     (op_count_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nof(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 32 : 1);
  endfunction

  function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    e.c = 1'b0;
    e.v = 1'b0;
    e.r = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.r = s[31:0];
        e.c = s[32];
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Present a request at a negedge, wait for acceptance; returns at the negedge after the accept edge.
  task automatic send(input int s, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    sel = s;
    req_command = cmd;
    req_operand_a = a;
    req_operand_b = b;
    req_valid = 1'b1;
    sb.push_back(model(cmd, a, b));
    while (!req_ready_w[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_exec", busy_w[s], 32'd1);
  endtask

  // Wait for the response, check latency/data, optionally stall with a follow-on request held.
  task automatic collect(input int s, input int stall, input bit pre,
                         input logic [2:0] pcmd, input logic [31:0] pa, input logic [31:0] pb);
    int n = 0;
    exp_t e;
    while (!resp_valid_w[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("resp_timeout", 32'd1, 32'd0);
      return;
    end
    check("latency", n, nof(s));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("result", resp_result_w[s], e.r);
    check("carryout", resp_carryout_w[s], e.c);
    check("zero", resp_zero_w[s], e.z);
    check("overflow", resp_overflow_w[s], e.v);
    if (pre) begin
      req_command = pcmd;
      req_operand_a = pa;
      req_operand_b = pb;
      req_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", resp_valid_w[s], 32'd1);
      check("stall_result", resp_result_w[s], e.r);
      check("stall_zero", resp_zero_w[s], e.z);
      check("stall_req_ready", req_ready_w[s], 32'd0);
      check("stall_op_count", op_count_w[s], exp_cnt[s] & 32'hFFFF);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt[s]++;
    check("op_count", op_count_w[s], exp_cnt[s] & 32'hFFFF);
    check("idle_after_resp", req_ready_w[s], 32'd1);
    if (pre) begin
      sb.push_back(model(pcmd, pa, pb));
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_accepted", busy_w[s], 32'd1);
    end
  endtask

  task automatic op(input int s, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    send(s, cmd, a, b);
    collect(s, 0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", req_ready_w[k], 32'd1);
      check("rst_resp_valid", resp_valid_w[k], 32'd0);
      check("rst_result", resp_result_w[k], 32'd0);
      check("rst_op_count", op_count_w[k], 32'd0);
      check("rst_busy", busy_w[k], 32'd0);
    end

    // Directed arithmetic and compare cases on the 8-bit slice instance.
    op(0, 3'd0, 32'd1, 32'd2);
    op(0, 3'd0, 32'h80000001, 32'h80000001);
    op(0, 3'd0, 32'h7FFFFFFF, 32'd1);
    op(0, 3'd1, 32'd3, 32'd3);
    op(0, 3'd1, 32'h80000000, 32'd1);
    op(0, 3'd1, 32'hFFFFFFFE, 32'd3);
    op(0, 3'd3, 32'd2, 32'd3);
    op(0, 3'd3, 32'd3, 32'd2);
    op(0, 3'd3, 32'hFFFFFFFF, 32'd1);
    op(0, 3'd3, 32'd1, 32'hFFFFFFFF);
    op(0, 3'd3, 32'h80000000, 32'd1);
    op(0, 3'd2, 32'hA5A5F00F, 32'h0FF0FFFF);
    op(0, 3'd4, 32'hF0F0F0F0, 32'h3C3C3C3C);

    // Backpressure with a follow-on request held during the stall.
    send(0, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect(0, 5, 1'b1, 3'd7, 32'd1, 32'd0);
    collect(0, 0, 1'b0, 3'd0, 32'd0, 32'd0);

    // Latency and carry chaining at SLICE_W = 1 and 32.
    for (int s = 1; s < 3; s++) begin
      op(s, 3'd0, 32'h80000001, 32'h80000001);
      op(s, 3'd1, 32'h80000000, 32'd1);
      op(s, 3'd3, 32'h80000000, 32'd1);
      op(s, 3'd6, 32'd0, 32'd0);
    end

    // Random mix across all three instances.
    for (int i = 0; i < 24; i++) begin
      op(i % 3, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    // Reset during EXEC slice 2 of the 8-bit instance.
    send(0, 3'd0, 32'h12345678, 32'h11111111);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
    check("midrst_req_ready", req_ready_w[0], 32'd1);
    check("midrst_resp_valid", resp_valid_w[0], 32'd0);
    check("midrst_op_count", op_count_w[0], 32'd0);
    check("midrst_result", resp_result_w[0], 32'd0);
    check("midrst_flags", {resp_carryout_w[0], resp_zero_w[0], resp_overflow_w[0]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid_w[0]) seen = 1'b1;
    end
    check("no_stale_resp", seen, 32'd0);
    op(0, 3'd6, 32'd0, 32'd0);
    op(1, 3'd6, 32'd0, 32'd0);
    op(2, 3'd6, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
